// File: rtl/unlock_access_arbiter.sv
// unlock_access_arbiter: round-robin sharing of one serial unlock FSM between NUM_REQ requesters.
// Define UNLOCK_ARB_STATS_EN to add saturating attempt_total / fail_total counters.
module unlock_access_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int CODE_W         = 4,
  parameter int MAX_FAILS      = 3,
  parameter int LOCKOUT_CYCLES = 16,
  parameter int RESP_TIMEOUT   = 8
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ*CODE_W-1:0]        code,
  output logic [NUM_REQ-1:0]               grant,
  output logic                             done,
  output logic                             result_ok,
  output logic [$clog2(NUM_REQ)-1:0]       result_id,
  output logic                             locked_out,
  output logic [$clog2(MAX_FAILS+1)-1:0]   fail_count,
  output logic                             serial_data,
  output logic                             serial_valid,
  input  logic                             serial_ready,
  input  logic                             unlock,
  input  logic                             pwd_incorrect
`ifdef UNLOCK_ARB_STATS_EN
  ,
  output logic [15:0]                      attempt_total,
  output logic [15:0]                      fail_total
`endif
);

  localparam int ID_W    = $clog2(NUM_REQ);
  localparam int FC_W    = $clog2(MAX_FAILS + 1);
  localparam int BIT_W   = (CODE_W > 1) ? $clog2(CODE_W) : 1;
  localparam int TMR_MAX = (LOCKOUT_CYCLES > RESP_TIMEOUT) ? LOCKOUT_CYCLES : RESP_TIMEOUT;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SEND, S_CHECK, S_RESULT, S_RECOVER, S_LOCKOUT
  } state_t;

  state_t            state, state_nxt;
  logic [CODE_W-1:0] code_q;
  logic [ID_W-1:0]   id_q, rr_ptr, win_id;
  logic              win_found;
  logic [BIT_W-1:0]  bit_idx;
  logic [TMR_W-1:0]  timer;
  logic              ok_q;
  logic              lock_idle;
  logic [FC_W-1:0]   fail_inc;

  // Serial handshake: a bit transfers on every clk edge where serial_valid && serial_ready;
  // serial_valid stays high and serial_data stable until that edge.
  assign lock_idle = serial_ready && !unlock && !pwd_incorrect;
  assign fail_inc  = (fail_count == FC_W'(MAX_FAILS)) ? fail_count : fail_count + FC_W'(1);
  assign result_ok = done & ok_q;
  assign result_id = done ? id_q : '0;

  // First active requester at or after the round-robin pointer.
  always_comb begin
    int idx;
    idx       = 0;
    win_found = 1'b0;
    win_id    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_REQ;
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_id    = ID_W'(idx);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    grant        = '0;
    serial_valid = 1'b0;
    serial_data  = 1'b0;
    done         = 1'b0;
    locked_out   = 1'b0;
    case (state)
      S_IDLE: begin
        if (win_found && lock_idle) begin
          grant     = NUM_REQ'(1) << win_id;
          state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        serial_valid = 1'b1;
        serial_data  = code_q[bit_idx];
        if (serial_ready) state_nxt = S_CHECK;
      end
      S_CHECK: begin
        if (pwd_incorrect || unlock)                   state_nxt = S_RESULT;
        else if (bit_idx != '0)                        state_nxt = S_SEND;
        else if (timer == TMR_W'(RESP_TIMEOUT - 1))    state_nxt = S_RESULT;
      end
      S_RESULT: begin
        done = 1'b1;
        if (!ok_q && fail_inc == FC_W'(MAX_FAILS)) state_nxt = S_LOCKOUT;
        else                                       state_nxt = S_RECOVER;
      end
      S_RECOVER: begin
        if (lock_idle) state_nxt = S_IDLE;
      end
      S_LOCKOUT: begin
        locked_out = 1'b1;
        if (timer == TMR_W'(LOCKOUT_CYCLES - 1)) state_nxt = S_RECOVER;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      code_q     <= '0;
      id_q       <= '0;
      rr_ptr     <= '0;
      bit_idx    <= '0;
      timer      <= '0;
      ok_q       <= 1'b0;
      fail_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (state_nxt == S_SEND) begin
            code_q  <= code[int'(win_id)*CODE_W +: CODE_W];
            id_q    <= win_id;
            bit_idx <= BIT_W'(CODE_W - 1);
            rr_ptr  <= (win_id == ID_W'(NUM_REQ - 1)) ? '0 : win_id + ID_W'(1);
          end
        end
        S_SEND: timer <= '0;
        S_CHECK: begin
          // Fail has priority when the lock raises both flags together.
          if (state_nxt == S_RESULT)    ok_q    <= unlock && !pwd_incorrect;
          else if (state_nxt == S_SEND) bit_idx <= bit_idx - BIT_W'(1);
          else                          timer   <= timer + TMR_W'(1);
        end
        S_RESULT: begin
          fail_count <= ok_q ? '0 : fail_inc;
          timer      <= '0;
        end
        S_LOCKOUT: begin
          timer <= timer + TMR_W'(1);
          if (state_nxt == S_RECOVER) fail_count <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef UNLOCK_ARB_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      attempt_total <= '0;
      fail_total    <= '0;
    end else if (done) begin
      if (attempt_total != 16'hFFFF)          attempt_total <= attempt_total + 16'd1;
      if (!ok_q && fail_total != 16'hFFFF)    fail_total    <= fail_total + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_unlock_access_arbiter.sv
// Bench for unlock_access_arbiter: behavioural lock FSM plus a round-robin / failure-count model.
module tb_unlock_access_arbiter;

  localparam int NUM_REQ        = 4;
  localparam int CODE_W         = 4;
  localparam int MAX_FAILS      = 3;
  localparam int LOCKOUT_CYCLES = 16;
  localparam int RESP_TIMEOUT   = 8;
  localparam logic [3:0] SECRET = 4'b1011;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [3:0]  req;
  logic [15:0] code;
  logic [3:0]  grant;
  logic        done, result_ok, locked_out;
  logic [1:0]  result_id, fail_count;
  logic        serial_data, serial_valid, serial_ready, unlock, pwd_incorrect;
`ifdef UNLOCK_ARB_STATS_EN
  logic [15:0] attempt_total, fail_total;
`endif

  int   checks, failures;
  int   rr_ptr, fcount;
  int   lk_idx, lk_hold;
  bit   lk_silent, lk_stall;
  logic beat_q[$];

  unlock_access_arbiter dut (
    .clk(clk), .reset_n(reset_n), .req(req), .code(code), .grant(grant),
    .done(done), .result_ok(result_ok), .result_id(result_id),
    .locked_out(locked_out), .fail_count(fail_count),
    .serial_data(serial_data), .serial_valid(serial_valid),
    .serial_ready(serial_ready), .unlock(unlock), .pwd_incorrect(pwd_incorrect)
`ifdef UNLOCK_ARB_STATS_EN
    , .attempt_total(attempt_total), .fail_total(fail_total)
`endif
  );

  always #5 clk = ~clk;

  // Lock FSM: checks each bit against SECRET MSB first, holds its flag 1-3 cycles, then idles.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      serial_ready  <= 1'b0;
      unlock        <= 1'b0;
      pwd_incorrect <= 1'b0;
      lk_idx        <= CODE_W - 1;
      lk_hold       <= 0;
    end else if (lk_hold != 0) begin
      lk_hold <= lk_hold - 1;
      if (lk_hold == 1) begin
        unlock        <= 1'b0;
        pwd_incorrect <= 1'b0;
        serial_ready  <= lk_stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      end else begin
        serial_ready <= 1'b0;
      end
    end else if (serial_valid && serial_ready) begin
      beat_q.push_back(serial_data);
      if (serial_data !== SECRET[lk_idx]) begin
        pwd_incorrect <= 1'b1;
        lk_hold       <= $urandom_range(1, 3);
        serial_ready  <= 1'b0;
        lk_idx        <= CODE_W - 1;
      end else if (lk_idx == 0) begin
        lk_idx <= CODE_W - 1;
        if (!lk_silent) begin
          unlock       <= 1'b1;
          lk_hold      <= $urandom_range(1, 3);
          serial_ready <= 1'b0;
        end else begin
          serial_ready <= lk_stall ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
      end else begin
        lk_idx       <= lk_idx - 1;
        serial_ready <= lk_stall ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end else begin
      serial_ready <= lk_stall ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [3:0] r);
    for (int k = 0; k < NUM_REQ; k++)
      if (r[(rr_ptr + k) % NUM_REQ]) return (rr_ptr + k) % NUM_REQ;
    return -1;
  endfunction

  // One full attempt: grant, beats, result, then fail_count and any lockout.
  task automatic do_attempt(input bit scramble, input bit drop_req, input bit keep_req,
                            input bit check_lat);
    int w, base, nbeats, lat, n;
    bit got, exp_ok, g_bad;
    logic [3:0] c;
    got = 0;
    #1;
    for (int i = 0; i < 500; i++) begin
      if (grant !== 4'b0) begin got = 1; break; end
      @(negedge clk); #1;
    end
    chk("grant_seen", 32'(got), 32'd1);
    if (!got) return;
    w = pick(req);
    chk("grant_id", 32'(grant), 32'd1 << w);
    rr_ptr = (w + 1) % NUM_REQ;
    c      = code[w*CODE_W +: CODE_W];
    base   = beat_q.size();
    nbeats = 0;
    exp_ok = !lk_silent;
    for (int b = CODE_W - 1; b >= 0; b--) begin
      nbeats++;
      if (c[b] !== SECRET[b]) begin exp_ok = 0; break; end
    end
    @(posedge clk); #1;
    if (scramble) code = 16'($urandom);
    if (drop_req) req[w] = 1'b0;
    lat = 0;
    got = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      lat++;
      if (check_lat && lat == 1) begin
        chk("first_beat_valid", 32'(serial_valid), 32'd1);
        chk("first_beat_data", 32'(serial_data), 32'(c[CODE_W-1]));
      end
      if (done === 1'b1) begin got = 1; break; end
    end
    chk("done_seen", 32'(got), 32'd1);
    if (!got) return;
    chk("result_ok", 32'(result_ok), 32'(exp_ok));
    chk("result_id", 32'(result_id), 32'(w));
    chk("beat_count", 32'(beat_q.size() - base), 32'(nbeats));
    for (int k = 0; k < nbeats && base + k < beat_q.size(); k++)
      chk("beat_bit", 32'(beat_q[base+k]), 32'(c[CODE_W-1-k]));
    if (check_lat) begin
      if (lk_silent)
        chk("timeout_latency", 32'(lat >= 2*CODE_W + RESP_TIMEOUT && lat <= 2*CODE_W + RESP_TIMEOUT + 1), 32'd1);
      else
        chk("ok_latency", 32'(lat), 32'(2*nbeats + 1));
    end
    fcount = exp_ok ? 0 : ((fcount < MAX_FAILS) ? fcount + 1 : MAX_FAILS);
    if (!keep_req) req[w] = 1'b0;
    @(negedge clk);
    chk("fail_count", 32'(fail_count), 32'(fcount));
    chk("no_grant_after_done", 32'(grant), 32'd0);
    if (fcount == MAX_FAILS) begin
      n = 0;
      g_bad = 0;
      while (locked_out === 1'b1 && n < 100) begin
        n++;
        if (grant !== 4'b0) g_bad = 1;
        @(negedge clk);
      end
      chk("lockout_len", 32'(n), 32'(LOCKOUT_CYCLES));
      chk("lockout_no_grant", 32'(g_bad), 32'd0);
      chk("fail_count_cleared", 32'(fail_count), 32'd0);
      fcount = 0;
    end
  endtask

  initial begin
    bit got;
    checks = 0; failures = 0; rr_ptr = 0; fcount = 0;
    lk_silent = 0; lk_stall = 0;
    req = '0; code = '0; reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_serial_valid", 32'(serial_valid), 32'd0);
    chk("rst_locked_out", 32'(locked_out), 32'd0);
    chk("rst_fail_count", 32'(fail_count), 32'd0);
    chk("rst_result_ok", 32'(result_ok), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Correct code from requester 0, exact latency.
    code = {4'h0, 4'h0, 4'h0, 4'b1011};
    req  = 4'b0001;
    do_attempt(0, 0, 0, 1);

    // Wrong first bit from requester 1: single beat, fail_count 1.
    code = {4'h0, 4'h0, 4'b0000, 4'b1011};
    req  = 4'b0010;
    do_attempt(0, 0, 0, 0);

    // Reset during SEND.
    code = {4'h0, 4'b1011, 4'h0, 4'h0};
    req  = 4'b0100;
    got  = 0;
    #1;
    for (int i = 0; i < 100; i++) begin
      if (grant !== 4'b0) begin got = 1; break; end
      @(negedge clk); #1;
    end
    chk("rst_test_grant", 32'(got), 32'd1);
    @(negedge clk);
    chk("send_before_reset", 32'(serial_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    rr_ptr = 0;
    fcount = 0;
    chk("midrst_serial_valid", 32'(serial_valid), 32'd0);
    chk("midrst_grant", 32'(grant), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_fail_count", 32'(fail_count), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    // All requesters held: rotation 0,1,2,3,0 from reset.
    code = {4{4'b1011}};
    req  = 4'b1111;
    for (int i = 0; i < 5; i++) do_attempt(0, 0, 1, 0);

    // Three wrong codes in a row: lockout, then grants resume.
    code = {4{4'b0000}};
    for (int i = 0; i < 3; i++) do_attempt(0, 0, 1, 0);
    code = {4{4'b1011}};
    do_attempt(0, 0, 0, 0);
    req = '0;
    @(negedge clk);

    // Lock never answers after the last bit: response timeout.
    lk_silent = 1;
    code = {4'h0, 4'h0, 4'h0, 4'b1011};
    req  = 4'b0001;
    do_attempt(0, 0, 0, 1);
    lk_silent = 0;

    // Randomised traffic with lock stalls, late code changes and dropped requests.
    lk_stall = 1;
    for (int it = 0; it < 40; it++) begin
      for (int r = 0; r < NUM_REQ; r++)
        if (!req[r]) code[r*CODE_W +: CODE_W] = ($urandom_range(0, 1) != 0) ? SECRET : 4'($urandom_range(0, 15));
      if (req == 4'b0 || $urandom_range(0, 2) == 0) req = req | 4'($urandom_range(1, 15));
      do_attempt(it % 5 == 1, it % 7 == 3, 0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
